// File: rtl/sevensegment_scan.sv
// Refresh scanner feeding the seven-segment driver: double-buffered 4-digit image,
// per-slot blanking interval against ghosting, optional leading-zero blanking.
module sevensegment_scan #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic [19:0] value,
    input  logic [3:0]  dpmask,
    input  logic        lzblank,
    output logic [4:0]  data,
    output logic [2:0]  digit,
    output logic        setdp,
    output logic        frame
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [4:0]    CODE_OFF   = 5'd31;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [1:0]     idx_r;
    logic [19:0]    act_value_r;
    logic [3:0]     act_dp_r;
    logic           act_lz_r;
    logic [19:0]    pend_value_r;
    logic [3:0]     pend_dp_r;
    logic           pend_lz_r;
    logic           pend_valid_r;
    logic [4:0]     data_r;
    logic [2:0]     digit_r;
    logic           setdp_r;
    logic           frame_r;
    logic [19:0]    eff_s;
    logic [4:0]     sel_code_s;
    logic           sel_dp_s;
    logic           commit_s;

    // Leading zeros from digit 3 downward become 31; digit 0 always shows.
    function automatic logic [19:0] eff_codes(input logic [19:0] codes, input logic lz);
        logic [19:0] res;
        logic        blanking;
        res      = codes;
        blanking = lz;
        for (int i = 3; i >= 1; i--) begin
            if (blanking && (codes[i*5 +: 5] == 5'd0)) begin
                res[i*5 +: 5] = CODE_OFF;
            end else begin
                blanking = 1'b0;
            end
        end
        return res;
    endfunction

    // Effective code and decimal point of the digit currently being scanned.
    always_comb begin
        eff_s    = eff_codes(act_value_r, act_lz_r);
        commit_s = frame_r;
        case (idx_r)
            2'd0:    begin sel_code_s = eff_s[4:0];   sel_dp_s = act_dp_r[0]; end
            2'd1:    begin sel_code_s = eff_s[9:5];   sel_dp_s = act_dp_r[1]; end
            2'd2:    begin sel_code_s = eff_s[14:10]; sel_dp_s = act_dp_r[2]; end
            2'd3:    begin sel_code_s = eff_s[19:15]; sel_dp_s = act_dp_r[3]; end
            default: begin sel_code_s = CODE_OFF;     sel_dp_s = 1'b0;        end
        endcase
    end

    // Slot counter, digit index, BLANK/SHOW state and registered driver outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r   <= '0;
            idx_r   <= 2'd0;
            state_r <= ST_BLANK;
            data_r  <= CODE_OFF;
            digit_r <= 3'd0;
            setdp_r <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
                idx_r <= idx_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + CW'(1);
                idx_r <= idx_r;
            end
            case (state_r)
                ST_BLANK: state_r <= (cnt_r == BLANK_LAST) ? ST_SHOW : ST_BLANK;
                ST_SHOW:  state_r <= (cnt_r == CNT_LAST) ? ST_BLANK : ST_SHOW;
                default:  state_r <= ST_BLANK;
            endcase
            if (state_r == ST_SHOW) begin
                digit_r <= {1'b0, idx_r} + 3'd1;
                data_r  <= sel_code_s;
                setdp_r <= sel_dp_s;
            end else begin
                digit_r <= 3'd0;
                data_r  <= CODE_OFF;
                setdp_r <= 1'b0;
            end
            frame_r <= (idx_r == 2'd3) && (cnt_r == CNT_LAST);
        end
    end

    // Pending/active image; a load on the commit edge goes straight to active.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            act_value_r  <= {4{CODE_OFF}};
            act_dp_r     <= 4'd0;
            act_lz_r     <= 1'b0;
            pend_value_r <= 20'd0;
            pend_dp_r    <= 4'd0;
            pend_lz_r    <= 1'b0;
            pend_valid_r <= 1'b0;
        end else if (load && commit_s) begin
            act_value_r  <= value;
            act_dp_r     <= dpmask;
            act_lz_r     <= lzblank;
            pend_valid_r <= 1'b0;
        end else if (load) begin
            pend_value_r <= value;
            pend_dp_r    <= dpmask;
            pend_lz_r    <= lzblank;
            pend_valid_r <= 1'b1;
        end else if (commit_s && pend_valid_r) begin
            act_value_r  <= pend_value_r;
            act_dp_r     <= pend_dp_r;
            act_lz_r     <= pend_lz_r;
            pend_valid_r <= 1'b0;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    assign data  = data_r;
    assign digit = digit_r;
    assign setdp = setdp_r;
    assign frame = frame_r;

endmodule

// File: tb/tb_sevensegment_scan.sv
// Directed bench for sevensegment_scan with PRESCALE=8, BLANK_CYCLES=2.
module tb_sevensegment_scan;

    localparam int P = 8;
    localparam int B = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [19:0] value = 20'd0;
    logic [3:0]  dpmask = 4'd0;
    logic        lzblank = 1'b0;
    logic [4:0]  data;
    logic [2:0]  digit;
    logic        setdp;
    logic        frame;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = -1;
    logic [19:0] exp_codes = {4{5'd31}};
    logic [3:0]  exp_dp = 4'd0;
    int          last_digit = 0;
    int          zero_run = 0;
    bit          seen_nz = 1'b0;

    sevensegment_scan #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .load    (load),
        .value   (value),
        .dpmask  (dpmask),
        .lzblank (lzblank),
        .data    (data),
        .digit   (digit),
        .setdp   (setdp),
        .frame   (frame)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: expected outputs follow from the cycle number and the expected image.
    task automatic step();
        int s;
        int ix;
        bit show;
        @(posedge clock);
        #1;
        cyc++;
        s    = cyc % P;
        ix   = (cyc / P) % 4;
        show = (s >= B);
        check("digit", 32'(digit), show ? 32'(ix + 1) : 32'd0);
        check("data", 32'(data), show ? 32'(exp_codes[ix*5 +: 5]) : 32'd31);
        check("setdp", 32'(setdp), show ? 32'(exp_dp[ix]) : 32'd0);
        check("frame", 32'(frame), (s == P - 1 && ix == 3) ? 32'd1 : 32'd0);
        if (digit != 3'd0) begin
            if (last_digit != 0)
                check("digit_hold", 32'(digit), 32'(last_digit));
            else if (seen_nz)
                check("blank_gap", (zero_run >= B) ? 32'd1 : 32'd0, 32'd1);
            seen_nz  = 1'b1;
            zero_run = 0;
        end else begin
            zero_run++;
        end
        last_digit = int'(digit);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_load(input logic [19:0] v, input logic [3:0] dp, input logic lz);
        value   = v;
        dpmask  = dp;
        lzblank = lz;
        load    = 1'b1;
        step();
        load    = 1'b0;
        value   = 20'd0;
        dpmask  = 4'd0;
        lzblank = 1'b0;
    endtask

    task automatic set_exp(input logic [19:0] v, input logic [3:0] dp);
        exp_codes = v;
        exp_dp    = dp;
    endtask

    task automatic reset_release();
        @(negedge clock);
        resetn     = 1'b1;
        cyc        = -1;
        last_digit = 0;
        zero_run   = 0;
        seen_nz    = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_data", 32'(data), 32'd31);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_setdp", 32'(setdp), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        reset_release();

        // Two blank frames, then a load in the middle of the AN1 slot.
        run_to(74);
        do_load({5'd4, 5'd3, 5'd2, 5'd1}, 4'b0100, 1'b0);
        run_to(95);
        set_exp({5'd4, 5'd3, 5'd2, 5'd1}, 4'b0100);

        // Leading-zero blanking with a nonzero inner digit.
        run_to(99);
        do_load({5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 1'b1);
        run_to(127);
        set_exp({5'd31, 5'd31, 5'd7, 5'd0}, 4'b0000);

        // All zeros: only digit 0 shows, dp still follows the mask.
        run_to(130);
        do_load(20'd0, 4'b1001, 1'b1);
        run_to(159);
        set_exp({5'd31, 5'd31, 5'd31, 5'd0}, 4'b1001);

        // Load A then B in one frame: only B is shown.
        run_to(165);
        do_load({5'd9, 5'd9, 5'd9, 5'd9}, 4'b1111, 1'b0);
        run_to(180);
        do_load({5'd5, 5'd6, 5'd7, 5'd8}, 4'b0010, 1'b0);
        run_to(191);
        set_exp({5'd5, 5'd6, 5'd7, 5'd8}, 4'b0010);

        // Pending D overtaken by C loaded exactly on the commit edge.
        run_to(210);
        do_load({5'd2, 5'd2, 5'd2, 5'd2}, 4'b1111, 1'b0);
        run_to(223);
        set_exp({5'd1, 5'd0, 5'd0, 5'd0}, 4'b0000);
        do_load({5'd1, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1);
        run_to(287);

        // Async reset mid-SHOW with a load still pending.
        run_to(290);
        do_load({5'd3, 5'd3, 5'd3, 5'd3}, 4'b1111, 1'b0);
        run_to(300);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_data", 32'(data), 32'd31);
        check("arst_digit", 32'(digit), 32'd0);
        check("arst_setdp", 32'(setdp), 32'd0);
        check("arst_frame", 32'(frame), 32'd0);
        repeat (2) @(posedge clock);
        set_exp({4{5'd31}}, 4'b0000);
        reset_release();

        // Stays blank until a fresh load commits.
        run_to(40);
        do_load({5'd10, 5'd11, 5'd12, 5'd13}, 4'b1111, 1'b0);
        run_to(63);
        set_exp({5'd10, 5'd11, 5'd12, 5'd13}, 4'b1111);
        run_to(95);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevensegment_scan.md
Name: sevensegment_scan

Overview:
- Refresh scanner that sits directly upstream of the seven-segment display driver.
- Holds a 4-digit display image, double-buffered so updates never tear mid-frame.
- Time-multiplexes the image onto the driver's data[4:0], digit[2:0] and setdp inputs.
- Inserts a blanking interval before each digit to prevent ghosting, and optionally blanks leading zeros.

Parameters:
- PRESCALE, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz).
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off. Legal range is 1 <= BLANK_CYCLES < PRESCALE.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- resetn, input, 1: asynchronous active-low reset.
- load, input, 1: one-cycle strobe that captures value, dpmask and lzblank into the pending register.
- value, input, 20: four 5-bit display codes. [4:0] is digit 0 (AN0) and [19:15] is digit 3 (AN3). Codes 0-31 follow the driver's code set; 31 means all segments off.
- dpmask, input, 4: decimal point enable per digit, bit i for digit i.
- lzblank, input, 1: leading-zero blanking enable.
- data, output, 5: code for the driver.
- digit, output, 3: driver digit select. 0 means all off; 1..4 select AN0..AN3.
- setdp, output, 1: decimal point request for the driver.
- frame, output, 1: one-cycle pulse on the last cycle of the digit-3 slot.

Behaviour:
- Reset (asynchronous, while resetn=0):
  - Active image = all codes 31, dpmask 0, lzblank 0.
  - Pending register cleared; pending-valid = 0.
  - idx = 0, slot counter = 0, state = BLANK.
  - Outputs: data = 31, digit = 0, setdp = 0, frame = 0.
- Slot counter:
  - Counts 0..PRESCALE-1, then wraps to 0 and advances idx (0, 1, 2, 3, 0, ...).
  - Counter width is clog2(PRESCALE).
- State machine, two states:
  - BLANK, for counter 0..BLANK_CYCLES-1: digit = 0, data = 31, setdp = 0.
  - SHOW, for counter BLANK_CYCLES..PRESCALE-1: digit = idx+1, data = effective code of idx, setdp = active dpmask[idx].
  - BLANK goes to SHOW when counter = BLANK_CYCLES-1. SHOW goes to BLANK on counter wrap.
- Output timing:
  - All outputs are registered, so each output reflects the state one cycle after the counter value.
  - Data is therefore stable across the driver's falling-edge sample.
- Effective code (combinational from the active image):
  - With lzblank = 1, scan from digit 3 downward; each digit whose code is 0 is replaced by 31 until the first nonzero code.
  - Digit 0 is never blanked, so value 0 displays "0".
  - With lzblank = 0, codes pass through unchanged.
  - The dp bit is unaffected by blanking.
- Double buffering:
  - load = 1 captures the inputs into pending and sets pending-valid.
  - Multiple loads before a commit: the last one wins.
- Commit:
  - Occurs on the clock edge where idx wraps 3->0, the same edge that follows the frame pulse.
  - If pending-valid, active <= pending and pending-valid is cleared.
  - If load = 1 on the commit edge itself, the load inputs bypass pending and commit directly (newest data wins), and pending-valid is cleared.
- Frame pulse:
  - frame = 1 exactly on the cycle where idx = 3 and counter = PRESCALE-1.
  - One pulse per 4*PRESCALE cycles.
- Reset mid-operation: immediate return to the reset state. Any pending load is discarded and the display is blank until the next load commits.
- No other inputs affect the scan rate. load has no backpressure.

Test Plan:
Directed scenarios use PRESCALE = 8 and BLANK_CYCLES = 2.
- Reset, then no load, for 64 cycles:
  - data stays 31.
  - digit follows the pattern 0,0,1×6 / 0,0,2×6 / 0,0,3×6 / 0,0,4×6.
  - frame pulses at cycles 31 and 63 after reset release (counted from the first posedge).
- load with value = {5'd4,5'd3,5'd2,5'd1}, dpmask = 4'b0100, lzblank = 0, mid digit-1 slot:
  - Rest of the current frame still shows 31.
  - After the next frame pulse, SHOW phases give data 1, 2, 3, 4 with digit 1, 2, 3, 4.
  - setdp = 1 only while digit = 3.
- lzblank = 1 with value codes {0,0,7,0} (digit3..digit0):
  - Digits 3 and 2 show 31; digit 1 shows 7; digit 0 shows 0.
  - Repeat with all codes zero: only digit 0 shows 0.
- Two loads (A, then B) inside one frame:
  - Only B appears after the commit; A is never displayed.
  - A load asserted exactly on the commit edge (cycle after frame) is displayed in the immediately following frame.
- Assert resetn = 0 asynchronously, mid-SHOW, with a pending load:
  - Outputs go to data = 31, digit = 0, setdp = 0 without waiting for a clock edge.
  - After release, the display stays blank until a new load commits.
- Check across all scenarios:
  - digit never goes directly from one nonzero value to another; at least BLANK_CYCLES cycles of digit = 0 separate them.
